// File: rtl/apb_req_fifo_pkt_if.sv
// Request-FIFO handshake bundle: APB-slave push side and arbiter pop side.
// Parity ports exist only when REQ_FIFO_PARITY_EN is defined.
interface apb_req_fifo_pkt_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_in;
  logic          push_write_in;
  logic [AW-1:0] push_addr_in;
  logic [DW-1:0] push_wdata_in;
  logic          data_in_ack;
  logic          full_o;
  logic          almost_full_o;
  logic [CW-1:0] count_o;
  logic          pop_in;
  logic          arb_req;
  logic          pkt_write_o;
  logic [AW-1:0] pkt_addr_o;
  logic [DW-1:0] pkt_wdata_o;
  logic          overflow_o;
  logic          underflow_o;
`ifdef REQ_FIFO_PARITY_EN
  logic          parity_inject_i;
  logic          parity_err_o;
`endif

  modport master (
    output push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
`ifdef REQ_FIFO_PARITY_EN
    output parity_inject_i,
    input  parity_err_o,
`endif
    input  data_in_ack, full_o, almost_full_o, count_o, arb_req,
           pkt_write_o, pkt_addr_o, pkt_wdata_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
`ifdef REQ_FIFO_PARITY_EN
    input  parity_inject_i,
    output parity_err_o,
`endif
    output data_in_ack, full_o, almost_full_o, count_o, arb_req,
           pkt_write_o, pkt_addr_o, pkt_wdata_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/apb_req_fifo_pkt.sv
// FWFT request-packet FIFO between APB slave and arbiter, with count, almost-full,
// flush and sticky overflow/underflow. Optional parity: define REQ_FIFO_PARITY_EN.
module apb_req_fifo_pkt #(
  parameter int DEPTH        = 8,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int AFULL_THRESH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  apb_req_fifo_pkt_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int PW    = 1 + AW + DW;
`ifdef REQ_FIFO_PARITY_EN
  localparam int EW    = PW + 1;
`else
  localparam int EW    = PW;
`endif
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_udf;

  logic             w_full;
  logic             w_nempty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [PW-1:0]    w_pkt;
  logic [EW-1:0]    w_wentry;
  logic [EW-1:0]    w_head;
  logic [PW-1:0]    w_head_pkt;

  always_comb begin
    w_full     = (r_count == FULL_CNT);
    w_nempty   = (r_count != '0);
    w_push_ok  = bus.push_in & ~w_full & ~clear_i;
    w_pop_ok   = bus.pop_in & w_nempty & ~clear_i;
    w_pkt      = {bus.push_write_in, bus.push_addr_in, bus.push_wdata_in};
`ifdef REQ_FIFO_PARITY_EN
    w_wentry   = {(^w_pkt) ^ bus.parity_inject_i, w_pkt};
`else
    w_wentry   = w_pkt;
`endif
    w_head     = r_mem[r_rd_ptr];
    w_head_pkt = w_nempty ? w_head[PW-1:0] : '0;
  end

  assign bus.data_in_ack   = w_push_ok;
  assign bus.full_o        = w_full;
  assign bus.almost_full_o = (r_count >= AFULL_CNT);
  assign bus.count_o       = r_count;
  assign bus.arb_req       = w_nempty;
  assign bus.pkt_write_o   = w_head_pkt[PW-1];
  assign bus.pkt_addr_o    = w_head_pkt[AW+DW-1:DW];
  assign bus.pkt_wdata_o   = w_head_pkt[DW-1:0];
  assign bus.overflow_o    = r_ovf;
  assign bus.underflow_o   = r_udf;
`ifdef REQ_FIFO_PARITY_EN
  // Stored bit is even parity over the packet, so a mismatch means corruption or injection.
  assign bus.parity_err_o  = w_nempty & ((^w_head[PW-1:0]) != w_head[EW-1]);
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_wentry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      r_ovf   <= r_ovf | (bus.push_in & w_full);
      r_udf   <= r_udf | (bus.pop_in & ~w_nempty);
    end
  end
endmodule

// File: doc/apb_req_fifo_pkt.md
Name: apb_req_fifo_pkt

Overview:
- Parametrised request FIFO between the APB slave and the round-robin arbiter.
- Each entry is one request packet: write flag, address and write data, stored as a single unit. Read and write requests share one pointer pair, so ordering is preserved.
- Head packet is presented first-word-fall-through together with arb_req. The arbiter grant pops it.
- Adds occupancy count, almost-full, synchronous flush and sticky overflow/underflow flags.

Parameters:
- DEPTH, 8, number of entries; power of 2, ≥2.
- AW, 32, address width.
- DW, 32, write-data width.
- AFULL_THRESH, 6, almost_full_o asserts when count ≥ this value; legal range 1..DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous flush.
- push_in  in  1  push request from APB slave.
- push_write_in  in  1  1 = write, 0 = read.
- push_addr_in  in  AW  request address.
- push_wdata_in  in  DW  write data; stored for reads too, value don't-care.
- data_in_ack  out  1  push accepted this cycle.
- full_o  out  1  FIFO full.
- almost_full_o  out  1  count ≥ AFULL_THRESH.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- pop_in  in  1  grant from arbiter.
- arb_req  out  1  FIFO non-empty.
- pkt_write_o  out  1  head write flag.
- pkt_addr_o  out  AW  head address.
- pkt_wdata_o  out  DW  head write data.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=0, async): rd_ptr = wr_ptr = 0, count = 0.
  - full_o = almost_full_o = arb_req = overflow_o = underflow_o = 0; data_in_ack = 0.
  - pkt_* = 0. Storage array is not reset.
- Pointers are PTR_W = $clog2(DEPTH) bits and wrap DEPTH-1 → 0. count is tracked separately; full/empty are derived from count, never from pointer compare.
- full_o = (count == DEPTH); arb_req = (count != 0); almost_full_o = (count ≥ AFULL_THRESH). All are combinational from registered state.
- Push:
  - data_in_ack = push_in & ~full_o & ~clear_i, combinational.
  - On an accepted push, {push_write_in, push_addr_in, push_wdata_in} is written to mem[wr_ptr] at posedge and wr_ptr increments.
- Pop:
  - pop_ok = pop_in & arb_req & ~clear_i.
  - pkt_* = mem[rd_ptr] whenever arb_req=1, else 0 (FWFT, zero latency).
  - On pop_ok, rd_ptr increments at posedge. The next head is visible the following cycle.
- Simultaneous push and pop:
  - Both accepted → count unchanged.
  - When full, the push is rejected (full_o is evaluated pre-edge) and the pop proceeds; count becomes DEPTH-1.
  - When empty, the pop is ignored and the push proceeds. Data is visible on pkt_* the next cycle, with no bypass.
- Count update: count_next = count + push_ok - pop_ok, where push_ok = data_in_ack.
- overflow_o sets on push_in & full_o & ~clear_i. underflow_o sets on pop_in & ~arb_req & ~clear_i. Both stay set until reset or clear_i.
- clear_i has priority over push and pop in the same cycle.
  - At the next edge: pointers and count go to 0 and both sticky flags clear.
  - Data in flight that cycle is discarded and data_in_ack = 0.
- Reset asserted mid-operation: all state clears immediately; contents are lost.
- Latency: push to arb_req = 1 cycle. Pop to next head = 1 cycle.

Optional Feature:
- Macro: REQ_FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed over {write, addr, wdata} at push.
  - Extra input parity_inject_i (1): when high during an accepted push, it inverts the stored parity bit.
  - Extra output parity_err_o (1) = arb_req & (recomputed head parity ≠ stored bit), combinational. A packet with an error is still popped normally on grant.
- Undefined: no parity storage, and neither parity port exists.

Test Plan (DEPTH=8, AFULL_THRESH=6):
- Reset, then idle 3 cycles → arb_req=0, full_o=0, count_o=0, pkt_*=0, flags=0.
- Push 8 packets, addr 0x100+4*i, wdata 0xA000_0000+i, writes alternating 1/0 → count_o steps 1..8; almost_full_o=1 from count 6; full_o=1 at 8; 9th push → data_in_ack=0, overflow_o=1 and stays 1.
- From full, pop 8 with pop_in held → pkt_addr_o sequence 0x100..0x11C in order with matching write/wdata; arb_req=0 after the 8th; 9th pop → underflow_o=1.
- Steady stream at count=3 with push and pop asserted 20 cycles (pointers wrap twice) → count_o stays 3, FIFO order preserved across wrap; at full, simultaneous push+pop → push rejected, count_o=7.
- count=5 with overflow_o=1; assert clear_i together with push_in and pop_in → next cycle count_o=0, arb_req=0, overflow_o=0, data_in_ack=0 during clear.
- REQ_FIFO_PARITY_EN: push addr 0x200 with parity_inject_i=1, then addr 0x204 clean → parity_err_o=1 while 0x200 is head, 0 after pop when 0x204 is head.
